// File: rtl/memory_game_seq_pkg.sv
// memory_game_pkg: shared state type, note constants and helpers for the tone-memory sequencer.
package memory_game_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, PLAY_NOTE, PLAY_GAP, WAIT_KEY, CHECK, WIN, FAIL} state_t;
    localparam int NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
    localparam int DEF_TICK_DIV = 5000000;
    // Patterns are zero-extended to the 16-note maximum so any idx selects in range.
    function automatic logic [NOTE_W-1:0] note_at(logic [63:0] pat, logic [3:0] idx);
        return pat[{idx, 2'b00} +: NOTE_W];
    endfunction
endpackage

// File: rtl/memory_game_seq_if.sv
// memory_game_seq_if: game control, keypad and piezo signals of the round sequencer.
interface memory_game_seq_if #(parameter int NOTES = 8);
    logic start;
    logic [4*NOTES-1:0] pattern;
    logic key_valid;
    logic [3:0] key_code;
    logic [3:0] note_out;
    logic [3:0] round;
    logic busy, await_key, win, fail;
    modport master (output start, pattern, key_valid, key_code,
                    input note_out, round, busy, await_key, win, fail);
    modport slave (input start, pattern, key_valid, key_code,
                   output note_out, round, busy, await_key, win, fail);
endinterface

// File: rtl/memory_game_seq_tick_gen.sv
// tick_gen: enabled prescaler giving a one-cycle tick every DIV enabled cycles; clr restarts it.
module tick_gen #(parameter int DIV = 4) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] count;
    assign tick = en && count == CW'(DIV - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else count <= (clr || tick) ? '0 : en ? count + CW'(1) : count;
endmodule

// File: rtl/memory_game_seq.sv
// memory_game_seq: replays a growing prefix of a latched note pattern and checks player keys.
// Define MEMORY_GAME_TIMEOUT_EN to fail when no key arrives within TIMEOUT_TICKS ticks.
module memory_game_seq
    import memory_game_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int NOTES = 8,
    parameter int TIMEOUT_TICKS = 30
) (
    input logic clk,
    input logic reset,
    memory_game_seq_if.slave bus
);
    state_t state, state_n;
    logic [4*NOTES-1:0] pat;
    logic [3:0] idx, idx_n, rnd, rnd_n, key;
    logic tick, en, timeout, key_hit;
    if (TICK_DIV < 2 || NOTES < 1 || NOTES > 16 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("memory_game_seq: illegal parameters");
    end
    assign key_hit = bus.key_valid && bus.key_code != NOTE_REST;
    assign bus.round = rnd;
    assign bus.busy = !(state inside {IDLE, WIN, FAIL});
    assign bus.await_key = state == WAIT_KEY;
    assign bus.win = state == WIN;
    assign bus.fail = state == FAIL;
`ifdef MEMORY_GAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] wait_ticks;
    assign en = state inside {PLAY_NOTE, PLAY_GAP, WAIT_KEY};
    assign timeout = tick && wait_ticks == TW'(TIMEOUT_TICKS - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) wait_ticks <= '0;
        else wait_ticks <= state == WAIT_KEY ? wait_ticks + TW'(tick) : '0;
`else
    assign en = state inside {PLAY_NOTE, PLAY_GAP};
    assign timeout = 1'b0;
`endif
    // Clearing on every state change makes each play state last exactly TICK_DIV cycles.
    tick_gen #(.DIV(TICK_DIV)) u_tick (.clk, .reset, .en, .clr(state_n != state), .tick);
    always_comb begin
        state_n = state;
        idx_n = idx;
        rnd_n = rnd;
        case (state)
            IDLE, WIN, FAIL: if (bus.start) begin
                state_n = LOAD;
                rnd_n = '0;
            end
            LOAD: begin
                state_n = PLAY_NOTE;
                idx_n = '0;
            end
            PLAY_NOTE: state_n = tick ? PLAY_GAP : PLAY_NOTE;
            PLAY_GAP: if (tick) begin
                state_n = idx == rnd ? WAIT_KEY : PLAY_NOTE;
                idx_n = idx == rnd ? '0 : idx + 4'd1;
            end
            WAIT_KEY: state_n = key_hit ? CHECK : timeout ? FAIL : WAIT_KEY;
            CHECK: if (key != note_at(64'(pat), idx)) state_n = FAIL;
            else if (idx != rnd) begin
                state_n = WAIT_KEY;
                idx_n = idx + 4'd1;
            end
            else if (rnd == 4'(NOTES - 1)) state_n = WIN;
            else begin
                state_n = PLAY_NOTE;
                idx_n = '0;
                rnd_n = rnd + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    // The first note leaves LOAD before pat is written, so it is taken from the live pattern.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            rnd <= '0;
            pat <= '0;
            key <= '0;
            bus.note_out <= NOTE_REST;
        end else begin
            state <= state_n;
            idx <= idx_n;
            rnd <= rnd_n;
            if (state == LOAD) pat <= bus.pattern;
            if (state == WAIT_KEY && key_hit) key <= bus.key_code;
            bus.note_out <= state_n == PLAY_NOTE
                ? note_at(64'(state == LOAD ? bus.pattern : pat), idx_n) : NOTE_REST;
        end
endmodule

// File: doc/memory_game_seq.md
# memory_game_seq

Round sequencer for the tone-memory game. It latches the 8-note answer pattern from the answer store, replays the first `round+1` notes on the piezo at a fixed tick rate, and collects player key presses. Each press is compared against the pattern. After a fully correct round it lengthens the sequence by one; on a mismatch it ends the game. It sits between the answer store, the keypad decoder and the piezo driver.

## Interface
- `TICK_DIV`, 5000000: clk cycles per note tick (0.1 s at 50 MHz); must be ≥ 2.
- `NOTES`, 8: pattern length in notes; must be ≤ 16.
- `TIMEOUT_TICKS`, 30: ticks allowed per key press; used only when `TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle pulse; begins a new game
- `pattern`  input  4*NOTES  note i is `pattern[4i+3:4i]`; code 0 is illegal in a pattern
- `key_valid`  input  1  one-cycle strobe for a key press
- `key_code`  input  4  pressed note, 1–15; 0 is ignored
- `note_out`  output  4  note to the piezo driver; 0 = silence
- `round`  output  4  current round, 0-based; sequence length is round+1
- `busy`  output  1  high in every state except IDLE, WIN and FAIL
- `await_key`  output  1  high in WAIT_KEY
- `win`  output  1  level; high in WIN
- `fail`  output  1  level; high in FAIL

## Operation
- States: IDLE, LOAD, PLAY_NOTE, PLAY_GAP, WAIT_KEY, CHECK, WIN, FAIL.
- IDLE, WIN, FAIL: `start` → LOAD; `round` := 0; `win` and `fail` clear.
- `start` is ignored while `busy` is high.
- LOAD, 1 cycle: latch `pattern` into an internal register. Later changes to `pattern` have no effect until the next `start`. Then `idx` := 0 → PLAY_NOTE.
- PLAY_NOTE: `note_out` = latched note[idx] for 1 tick → PLAY_GAP.
- PLAY_GAP: `note_out` = 0 for 1 tick. Then:
  - if idx == round: idx := 0 → WAIT_KEY;
  - otherwise idx++ → PLAY_NOTE.
- WAIT_KEY: the first `key_valid` with `key_code` ≠ 0 is registered → CHECK.
- CHECK, 1 cycle:
  - mismatch with note[idx] → FAIL;
  - match and idx < round → idx++ → WAIT_KEY;
  - match, idx == round and round == NOTES-1 → WIN;
  - match, idx == round otherwise → round++, idx := 0 → PLAY_NOTE.
- `key_valid` outside WAIT_KEY is dropped; there is no queueing.
- During WAIT_KEY, CHECK, WIN, FAIL and IDLE, `note_out` is 0.
- Low `reset` at any time returns the block to IDLE immediately. Outputs at reset: all 0.

## Timing
- Tick prescaler:
  - counts 0..TICK_DIV-1 while in PLAY_NOTE or PLAY_GAP, and wraps;
  - the tick pulse is high in the cycle where count == TICK_DIV-1;
  - the counter is cleared on every state entry, so each play state lasts exactly TICK_DIV cycles.
- `start` at cycle 0 → LOAD at cycle 1 → the first note appears on `note_out` at cycle 2.
- A key strobe in cycle n (WAIT_KEY) → CHECK in n+1 → next state in n+2. A second strobe in n+1 is dropped.
- Replay of a new round begins the cycle after CHECK.
- `note_out`, `round`, `win` and `fail` are all registered outputs.

## Configuration
- `MEMORY_GAME_TIMEOUT_EN` defined:
  - a tick counter runs in WAIT_KEY and restarts on each entry to WAIT_KEY;
  - reaching TIMEOUT_TICKS ticks → FAIL;
  - a key strobe in the same cycle as the timeout wins, and the block goes to CHECK.
- Undefined: WAIT_KEY waits indefinitely, and no timeout logic is built.

## Structure
- Package `memory_game_pkg`:
  - state enum;
  - `NOTE_W` = 4;
  - `NOTE_REST` = 4'h0;
  - default `TICK_DIV`.
- Sub-module `tick_gen`: prescaler with enable and clear inputs and a one-cycle `tick` output. It is shared with the timeout counter.

## Test plan
All scenarios use TICK_DIV = 4, pattern = 0x87654321.
- Reset low mid-PLAY_NOTE → next cycle: IDLE, `note_out` = 0, `round` = 0, `busy` = 0.
- `start` → `note_out` = 1 for 4 cycles, then 0 for 4 cycles; then `await_key` = 1.
- Round 0: key 1 → `round` = 1; replay shows 1, 0, 2, 0, each for 4 cycles.
- Round 1: keys 1 then 3 → `fail` = 1, `busy` = 0; a later `start` clears `fail` and restarts at `round` 0.
- Full correct play through round 7 (last keys 1..8) → `win` = 1, `round` = 7; a key press in WIN is ignored.
- Key strobe during PLAY_NOTE, and key_code 0 in WAIT_KEY → both ignored. With `MEMORY_GAME_TIMEOUT_EN` and TIMEOUT_TICKS = 3: no key for 12 cycles → `fail` = 1.
